// File: rtl/apu_pulse.sv
// apu_pulse: NES-style pulse channel (duty sequencer, envelope, length counter, optional sweep)
// Ports: clk/rst (sync active-high); reg0..reg3 channel registers with reg1_wr/reg2_wr/reg3_wr strobes;
//        apu_tick/quarter_frame/half_frame frame-sequencer enables; chan_en; pulse_out (4-bit sample); length_active.
// Build option: define APU_SWEEP_EN to include the sweep unit; CHANNEL picks its negate flavour.
module apu_pulse #(
   parameter int CHANNEL = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] reg0,
   input  logic [7:0] reg1,
   input  logic [7:0] reg2,
   input  logic [7:0] reg3,
   input  logic       reg1_wr,
   input  logic       reg2_wr,
   input  logic       reg3_wr,
   input  logic       apu_tick,
   input  logic       quarter_frame,
   input  logic       half_frame,
   input  logic       chan_en,
   output logic [3:0] pulse_out,
   output logic       length_active
);
   localparam logic [7:0] LEN_TBL [32] = '{
      8'd10, 8'd254, 8'd20, 8'd2, 8'd40, 8'd4, 8'd80, 8'd6,
      8'd160, 8'd8, 8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
      8'd12, 8'd16, 8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
      8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30};
   logic [10:0] period, timer, swp_period;
   logic [2:0]  step;
   logic        env_start, mute, duty_bit, swp_upd;
   logic [3:0]  env_div, decay, vol;
   logic [7:0]  len, duty_pat;
   always_comb begin
      duty_pat = reg0[7:6] == 2'b00 ? 8'b0100_0000 :
                 reg0[7:6] == 2'b01 ? 8'b0110_0000 :
                 reg0[7:6] == 2'b10 ? 8'b0111_1000 : 8'b1001_1111;
      duty_bit = duty_pat[step];
      vol      = reg0[4] ? reg0[3:0] : decay;
   end
   assign length_active = len != 8'd0;
`ifdef APU_SWEEP_EN
   logic [2:0]  swp_div;
   logic        swp_reload;
   logic [10:0] change;
   logic [11:0] target;
   // CHANNEL 0 negates with ones' complement, hence the extra -1
   always_comb begin
      change     = period >> reg1[2:0];
      target     = reg1[3] ? {1'b0, period} - {1'b0, change} - ((CHANNEL == 0) ? 12'd1 : 12'd0)
                           : {1'b0, period} + {1'b0, change};
      mute       = period < 11'd8 || target[11];
      swp_upd    = half_frame && swp_div == 3'd0 && reg1[7] && reg1[2:0] != 3'd0 && !mute;
      swp_period = target[10:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         swp_div    <= '0;
         swp_reload <= 1'b0;
      end else begin
         if (half_frame) begin
            if (swp_div == 3'd0 || swp_reload) begin
               swp_div    <= reg1[6:4];
               swp_reload <= 1'b0;
            end else begin
               swp_div <= swp_div - 3'd1;
            end
         end
         if (reg1_wr) swp_reload <= 1'b1;
      end
   end
`else
   logic unused_sweep;
   assign unused_sweep = ^{reg1, reg1_wr, CHANNEL != 0};
   always_comb begin
      mute       = period < 11'd8;
      swp_upd    = 1'b0;
      swp_period = period;
   end
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         period    <= '0;
         timer     <= '0;
         step      <= '0;
         env_start <= 1'b0;
         env_div   <= '0;
         decay     <= '0;
         len       <= '0;
         pulse_out <= '0;
      end else begin
         if (reg2_wr || reg3_wr) period <= {reg3[2:0], reg2};
         else if (swp_upd) period <= swp_period;
         if (apu_tick) begin
            if (timer == 11'd0) begin
               timer <= period;
               step  <= step - 3'd1;
            end else begin
               timer <= timer - 11'd1;
            end
         end
         if (reg3_wr) step <= '0;
         if (quarter_frame) begin
            if (env_start) begin
               env_start <= 1'b0;
               decay     <= 4'd15;
               env_div   <= reg0[3:0];
            end else if (env_div == 4'd0) begin
               env_div <= reg0[3:0];
               if (decay != 4'd0) decay <= decay - 4'd1;
               else if (reg0[5]) decay <= 4'd15;
            end else begin
               env_div <= env_div - 4'd1;
            end
         end
         if (reg3_wr) env_start <= 1'b1;
         if (!chan_en) len <= '0;
         else if (reg3_wr) len <= LEN_TBL[reg3[7:3]];
         else if (half_frame && len != 8'd0 && !reg0[5]) len <= len - 8'd1;
         pulse_out <= (len == 8'd0 || mute || !duty_bit) ? 4'd0 : vol;
      end
   end
endmodule
